// File: rtl/frame_scheduler_if.sv
// Handshake/configuration bundle between a frame-rate host and frame_scheduler.
// The slave modport is the scheduler's view; master is the driving side.
interface frame_scheduler_if #(
  parameter int PERIOD_W = 24,
  parameter int FRAME_W  = 16
);
  logic                enable;
  logic                oneShot;
  logic                periodLoad;
  logic [PERIOD_W-1:0] periodIn;
  logic                clearErr;
  logic                Ready2Go;
  logic                allDone;
  logic                Cycle;
  logic                busy;
  logic [FRAME_W-1:0]  frameCount;
  logic                overrun;
  logic                timeoutErr;

  modport slave (
    input  enable, oneShot, periodLoad, periodIn, clearErr, Ready2Go, allDone,
    output Cycle, busy, frameCount, overrun, timeoutErr
  );

  modport master (
    output enable, oneShot, periodLoad, periodIn, clearErr, Ready2Go, allDone,
    input  Cycle, busy, frameCount, overrun, timeoutErr
  );
endinterface

// File: rtl/frame_scheduler.sv
// Frame-rate controller for the WS2812B path: periodic/one-shot Go pulses, frame count,
// overrun and allDone watchdog. Optional macro SYNC_RESTART_EN: frame on enable rising edge.
//   state     | meaning
//   SIDLE     | waiting for a pending request and Ready2Go
//   SGO       | one-cycle Cycle pulse, request consumed
//   SWAITDONE | frame in flight, watchdog running
//   SERR      | watchdog expired, halted until clearErr
module frame_scheduler #(
  parameter int PERIOD_W       = 24,
  parameter int DEFAULT_PERIOD = 1666667,
  parameter int TIMEOUT_CYC    = 200000,
  parameter int FRAME_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  frame_scheduler_if.slave   bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0] SIDLE     = 2'd0;
  localparam logic [1:0] SGO       = 2'd1;
  localparam logic [1:0] SWAITDONE = 2'd2;
  localparam logic [1:0] SERR      = 2'd3;
  localparam logic [PERIOD_W-1:0] DEF_P   = PERIOD_W'(DEFAULT_PERIOD);
  localparam logic [WD_W-1:0]     WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [1:0]          r_state;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic [WD_W-1:0]     r_wd;
  logic [FRAME_W-1:0]  r_frames;
  logic                r_pending;
  logic                r_overrun;
  logic                r_timeout;

  logic                w_tick;
  logic                w_req;
  logic                w_restart;
  logic                w_err_ovr;
  logic                w_err_to;
  logic [PERIOD_W-1:0] w_reload_val;

`ifdef SYNC_RESTART_EN
  logic r_en_d;
  always_ff @(posedge clk) begin
    if (reset) r_en_d <= 1'b0;
    else       r_en_d <= bus.enable;
  end
  assign w_restart = bus.enable & ~r_en_d;
`else
  assign w_restart = 1'b0;
`endif

  assign w_reload_val = r_period - PERIOD_W'(1);
  assign w_tick       = bus.enable && (r_cnt == '0);
  assign w_req        = w_tick | bus.oneShot;
  // A request landing in SGO simply re-arms pending; only an already-armed request is lost.
  assign w_err_ovr    = w_req & r_pending & (r_state != SGO);
  assign w_err_to     = (r_state == SWAITDONE) & ~bus.allDone & (r_wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_period <= DEF_P;
      r_cnt    <= DEF_P - PERIOD_W'(1);
    end else begin
      if (bus.periodLoad)
        r_period <= (bus.periodIn == '0) ? PERIOD_W'(1) : bus.periodIn;
      if (!bus.enable || w_tick || w_restart) r_cnt <= w_reload_val;
      else                                    r_cnt <= r_cnt - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == SGO)          r_pending <= w_req | w_restart;
      else if (w_req || w_restart) r_pending <= 1'b1;
      r_overrun <= w_err_ovr | (r_overrun & ~bus.clearErr);
      r_timeout <= w_err_to  | (r_timeout & ~bus.clearErr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= SIDLE;
      r_wd     <= '0;
      r_frames <= '0;
    end else begin
      case (r_state)
        SIDLE: if (r_pending && bus.Ready2Go) r_state <= SGO;
        SGO: begin
          r_wd    <= '0;
          r_state <= SWAITDONE;
        end
        SWAITDONE: begin
          r_wd <= r_wd + WD_W'(1);
          if (bus.allDone) begin
            r_frames <= r_frames + FRAME_W'(1);
            r_state  <= SIDLE;
          end else if (r_wd == WD_LAST) begin
            r_state <= SERR;
          end
        end
        SERR: if (bus.clearErr) r_state <= SIDLE;
        default: r_state <= SIDLE;
      endcase
    end
  end

  // Gated by reset so no Go pulse escapes during the reset cycle itself.
  assign bus.Cycle      = (r_state == SGO) & ~reset;
  assign bus.busy       = (r_state == SGO) | (r_state == SWAITDONE);
  assign bus.frameCount = r_frames;
  assign bus.overrun    = r_overrun;
  assign bus.timeoutErr = r_timeout;

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Frame-rate controller for the WS2812B output path.
- Generates the one-cycle `Cycle` ("Go") pulse that starts the ship/reset sequence, either periodically (free-running refresh) or on a single-shot request.
- Issues `Cycle` only while the ship controller reports `Ready2Go`; completion is taken from `allDone`.
- Counts completed frames, flags overruns (frame requested while one is still pending), and runs a watchdog on `allDone`.

Parameters:
- PERIOD_W, 24, width of frame-period register/counter (clock cycles).
- DEFAULT_PERIOD, 1666667, reset frame period in cycles (60 Hz at 100 MHz).
- TIMEOUT_CYC, 200000, max cycles from `Cycle` to `allDone` before timeout (2 ms at 100 MHz).
- FRAME_W, 16, width of `frameCount`.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  level; 1 = periodic refresh running
- oneShot  in  1  one-cycle pulse; request a single frame
- periodLoad  in  1  one-cycle pulse; latch `periodIn`
- periodIn  in  PERIOD_W  new frame period in cycles
- clearErr  in  1  one-cycle pulse; clears sticky flags, exits SERR
- Ready2Go  in  1  from ship controller; 1 = idle, may start
- allDone  in  1  from GRB shifter; reset code sent, frame complete
- Cycle  out  1  one-cycle start pulse to ship controller
- busy  out  1  1 in SGO or SWAITDONE
- frameCount  out  FRAME_W  completed frames, wraps
- overrun  out  1  sticky; a request was lost
- timeoutErr  out  1  sticky; `allDone` not seen within TIMEOUT_CYC

Behaviour:
- Reset:
  - state = SIDLE; Cycle = busy = overrun = timeoutErr = 0; frameCount = 0; pending = 0.
  - period reg = DEFAULT_PERIOD; period counter = DEFAULT_PERIOD-1; watchdog = 0.
  - Reset mid-frame abandons the frame; no `Cycle` on the reset cycle or the cycle after.
- Period counter:
  - Decrements only while enable=1.
  - At 0: asserts internal tick for 1 cycle and reloads period reg-1.
  - While enable=0 it holds at period reg-1.
  - periodLoad updates the period reg immediately; the counter adopts it at the next reload.
  - periodIn=0 is stored as 1, giving a tick every cycle.
- Request latch:
  - pending sets on tick or oneShot; tick and oneShot in the same cycle set a single request.
  - If pending is already 1 when a new tick/oneShot arrives: overrun <= 1, request dropped.
  - pending clears in SGO.
- FSM states: SIDLE, SGO, SWAITDONE, SERR.
  - SIDLE: if pending & Ready2Go -> SGO; otherwise stay.
  - SGO, exactly 1 cycle:
    - Cycle=1; pending <= 0; watchdog <= 0.
    - A request arriving in this same cycle re-sets pending (not overrun).
    - -> SWAITDONE.
  - SWAITDONE:
    - busy=1; watchdog increments each cycle.
    - On allDone: frameCount <= frameCount+1 (mod 2^FRAME_W) -> SIDLE.
    - Else if watchdog == TIMEOUT_CYC-1: timeoutErr <= 1 -> SERR.
    - allDone and timeout in the same cycle: allDone wins.
  - SERR:
    - No `Cycle` issued; requests still latch, overrun logic still active.
    - clearErr -> SIDLE.
- Flags and sampling:
  - clearErr clears overrun and timeoutErr. If a new error event and clearErr coincide, the flag ends at 1.
  - allDone is ignored outside SWAITDONE. Ready2Go is sampled only in SIDLE.
- Latency: pending set at edge N, Ready2Go=1 -> Cycle=1 in cycle N+1 (state SGO).
- Minimum Cycle-to-Cycle spacing is 3 cycles.

Optional Feature:
- Macro SYNC_RESTART_EN.
- Defined:
  - A 0->1 transition on enable (registered edge detect) reloads the period counter with period reg-1 and sets pending in the same cycle.
  - This gives an immediate first frame, then period-aligned frames.
  - The restart request does not count as overrun if pending is already 1.
- Undefined: the enable edge has no special effect; the first frame occurs at the first natural tick.

Test Plan:
- Reset, enable=1, periodLoad periodIn=10, Ready2Go=1, allDone pulsed 2 cycles after each Cycle -> Cycle every 10 cycles; frameCount=3 after 3 frames.
- oneShot with enable=0, Ready2Go=0 for 5 cycles then 1 -> exactly one Cycle, 1 cycle after Ready2Go rises; busy until allDone.
- periodIn=4, allDone withheld for 20 cycles -> second tick sets pending, third tick sets overrun=1; clearErr -> overrun=0.
- TIMEOUT_CYC=8, no allDone after Cycle -> timeoutErr=1 at cycle 8, state SERR, no further Cycle despite ticks; clearErr -> pending frame ships next cycle with Ready2Go=1.
- frameCount preset near wrap (FRAME_W=4, 16 frames) -> 15 -> 0; allDone on the same cycle as watchdog expiry -> frameCount increments, timeoutErr=0.
- reset asserted in SWAITDONE -> all outputs 0 next cycle; pending from before reset discarded. With SYNC_RESTART_EN: enable 0->1 -> Cycle 2 cycles later, then every period.
